mips_avalon_mem_bridge: RTL
===========================

Name: mips_avalon_mem_bridge

Overview:
Memory-side responder for the multicycle MIPS control FSM. It accepts single-word read/write requests from the CPU datapath, where the address is selected by IorD and writes are driven by the store path. It converts each request into an Avalon-MM master transaction that honours waitrequest, and returns read data plus a one-cycle completion pulse. The CPU FSM holds its current EXEC state until that pulse arrives.

Parameters:
TIMEOUT_CYCLES, 256, maximum consecutive cycles waitrequest may stay high before the transfer is aborted with an error (must be >= 1).
CHECK_ALIGN, 1, when 1, requests with addr[1:0] != 0 are rejected without a bus access.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  request strobe, sampled only in IDLE
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  32  byte address
cpu_wdata  input  32  write data
cpu_be  input  4  write byte enables (ignored for reads)
cpu_rdata  output  32  last completed read data, held until next read completes
cpu_done  output  1  one-cycle completion pulse
cpu_err  output  1  one-cycle pulse coincident with cpu_done on misalign or timeout
cpu_busy  output  1  high whenever state != IDLE
avm_address  output  32  Avalon address
avm_read  output  1  Avalon read strobe
avm_write  output  1  Avalon write strobe
avm_writedata  output  32  Avalon write data
avm_byteenable  output  4  Avalon byte enables
avm_waitrequest  input  1  slave stall
avm_readdata  input  32  read data, valid exactly one cycle after read accepted

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Reset asserted mid-transfer: strobes drop immediately and state returns to IDLE; no done or err pulse is generated.
- States: IDLE, ISSUE, RDATA, RESP, ERROR.
- IDLE:
  - On cpu_req: latch addr, wdata, be and we.
  - If CHECK_ALIGN=1 and cpu_addr[1:0] != 0, go to ERROR.
  - Otherwise go to ISSUE.
  - cpu_req is ignored in every other state; it is not queued.
- ISSUE:
  - avm_read = !we_latched; avm_write = we_latched.
  - avm_address = latched addr; avm_writedata = latched wdata.
  - avm_byteenable = latched be for writes, 4'hF for reads.
  - Address, data and byteenable stay stable while waitrequest=1.
  - Transfer is accepted in a cycle where a strobe is high and waitrequest=0. On acceptance, strobes drop next cycle:
    - write goes to RESP;
    - read goes to RDATA.
  - Each cycle with waitrequest=1 increments the counter. When the counter reaches TIMEOUT_CYCLES-1 with waitrequest still 1: strobes drop and the state goes to ERROR.
- RDATA: capture avm_readdata into cpu_rdata, go to RESP.
- RESP: cpu_done=1 for one cycle, go to IDLE.
- ERROR:
  - cpu_done=1 and cpu_err=1 for one cycle, go to IDLE.
  - cpu_rdata is unchanged.
- Latency with zero wait states, counted from the cpu_req edge to the cpu_done high cycle:
  - write: strobe in cycle 1, done in cycle 2;
  - read: strobe in cycle 1, data captured in cycle 2, done in cycle 3;
  - each waitrequest cycle adds 1;
  - misaligned request: done+err in cycle 1, with no strobe ever raised.
- cpu_busy = (state != IDLE).
- A new request may be sampled in the cycle after cpu_done, because the state is IDLE again then.
- The timeout counter clears on entry to ISSUE.

Test Plan:
- Aligned read, addr=0x00000010, waitrequest=0, readdata=0xDEADBEEF the cycle after acceptance -> avm_read high exactly 1 cycle; cpu_done in cycle 3 with cpu_rdata=0xDEADBEEF and cpu_err=0.
- Write, addr=0x24, wdata=0x12345678, be=4'b0011, waitrequest high for 3 cycles -> avm_write held 4 cycles with stable address, data and byteenable=0011; cpu_done in cycle 5.
- Misaligned read, addr=0x00000013 -> no avm strobe; cpu_done=cpu_err=1 in cycle 1; cpu_rdata keeps its prior value.
- TIMEOUT_CYCLES=4 with waitrequest stuck at 1 -> avm_read high for 4 cycles then low; cpu_done=cpu_err=1 in the next cycle; state returns to IDLE.
- cpu_req pulsed while busy, then back-to-back requests -> the busy-time request is ignored; the request sampled the cycle after cpu_done issues normally.
- Reset asserted in ISSUE with waitrequest=1 -> avm_read=0, cpu_busy=0, cpu_done=0 immediately; after release, the next read completes normally.

Source files
------------

// File: rtl/mips_avalon_mem_bridge.sv
// Bridges single-word CPU memory requests onto an Avalon-MM master port, with
// alignment checking, waitrequest timeout and a one-cycle completion pulse.
module mips_avalon_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CHECK_ALIGN    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StRdata, StResp, StError} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;

  logic [31:0] cpu_rdata_d, avm_address_d, avm_writedata_d;
  logic [3:0]  avm_byteenable_d;
  logic        cpu_done_d, cpu_err_d, cpu_busy_d, avm_read_d, avm_write_d;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    we_d             = we_q;
    cpu_rdata_d      = cpu_rdata;
    cpu_done_d       = 1'b0;
    cpu_err_d        = 1'b0;
    avm_address_d    = avm_address;
    avm_writedata_d  = avm_writedata;
    avm_byteenable_d = avm_byteenable;
    avm_read_d       = avm_read;
    avm_write_d      = avm_write;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          we_d             = cpu_we;
          avm_address_d    = cpu_addr;
          avm_writedata_d  = cpu_wdata;
          avm_byteenable_d = cpu_we ? cpu_be : 4'hF;
          if ((CHECK_ALIGN != 0) && (cpu_addr[1:0] != 2'b00)) begin
            state_d    = StError;
            cpu_done_d = 1'b1;
            cpu_err_d  = 1'b1;
          end else begin
            state_d     = StIssue;
            cnt_d       = '0;
            avm_read_d  = !cpu_we;
            avm_write_d = cpu_we;
          end
        end
      end
      StIssue: begin
        // A strobe is always high in this state, so acceptance is just !waitrequest.
        if (!avm_waitrequest) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (we_q) begin
            state_d    = StResp;
            cpu_done_d = 1'b1;
          end else begin
            state_d = StRdata;
          end
        end else if (cnt_q == CntMax) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          state_d     = StError;
          cpu_done_d  = 1'b1;
          cpu_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdata: begin
        cpu_rdata_d = avm_readdata;
        state_d     = StResp;
        cpu_done_d  = 1'b1;
      end
      StResp:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    cpu_busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      cpu_rdata      <= '0;
      cpu_done       <= 1'b0;
      cpu_err        <= 1'b0;
      cpu_busy       <= 1'b0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      cpu_rdata      <= cpu_rdata_d;
      cpu_done       <= cpu_done_d;
      cpu_err        <= cpu_err_d;
      cpu_busy       <= cpu_busy_d;
      avm_address    <= avm_address_d;
      avm_read       <= avm_read_d;
      avm_write      <= avm_write_d;
      avm_writedata  <= avm_writedata_d;
      avm_byteenable <= avm_byteenable_d;
    end
  end

endmodule
